tmr_reg_bank: RTL and testbench
===============================

TMR_REG_BANK -- requirements
Module: tmr_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bits per voted word, legal range 1..16.
REQ-002 SHALL have parameter CNT_W, default 8: width of the error counter, legal range 1..16.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port mode, input, 2: 00 hold, 01 parallel load, 10 shift left, 11 rotate left.
REQ-006 SHALL have port din, input, WIDTH: parallel load data.
REQ-007 SHALL have port sin, input, 1: serial input for shift mode.
REQ-008 SHALL have port scrub_en, input, 1: in hold mode, rewrite all copies with the voted word.
REQ-009 SHALL have port inj_en, input, 1: fault-injection strobe.
REQ-010 SHALL have port inj_copy, input, 2: target copy 0..2; value 3 means no target.
REQ-011 SHALL have port inj_bit, input, clog2(WIDTH) (minimum 1): bit to invert.
REQ-012 SHALL have port err_clr, input, 1: clear the error counter.
REQ-013 SHALL have port q, output, WIDTH: bitwise 2-of-3 majority of copies c0, c1, c2.
REQ-014 SHALL have port err, output, 1: 1 when any bit of c0, c1, c2 disagrees.
REQ-015 SHALL have port copy_err, output, 3: bit k is 1 when ck differs from q in any bit.
REQ-016 SHALL have port err_cnt, output, CNT_W: saturating count of edges sampled with err=1.

Function
REQ-017 SHALL hold three WIDTH-bit copy registers c0, c1, c2. q, err and copy_err SHALL be combinational from these registers only, with zero latency.
REQ-018 SHALL compute next word N from q (never from an individual copy):
- hold: N = q
- load: N = din
- shift: N = {q[WIDTH-2:0], sin}
- rotate: N = {q[WIDTH-2:0], q[WIDTH-1]}
- WIDTH=1: shift gives sin; rotate gives q.
REQ-019 SHALL write N into all three copies when mode is not hold; this inherently corrects any single-copy fault.
REQ-020 SHALL, in hold mode with scrub_en=0, leave each copy unchanged so that faults persist; with scrub_en=1, write q into all three copies.
REQ-021 SHALL, when inj_en=1, inj_copy<3 and inj_bit<WIDTH, invert bit inj_bit of the value written into copy inj_copy on that edge. This applies after mode/scrub selection, in every mode.
REQ-022 SHALL ignore injection when inj_copy=3 or inj_bit>=WIDTH.
REQ-023 SHALL increment err_cnt by 1 on each edge where err=1, holding at 2^CNT_W-1 (no wrap).
REQ-024 SHALL set err_cnt to 0 on an edge with err_clr=1; err_clr takes priority over a simultaneous increment.
REQ-025 SHALL follow the majority when two copies are corrupted in the same bit: q then carries the wrong value, and err=1 with copy_err flagging the single correct copy. This is an out-of-model condition and needs no further handling.
REQ-026 SHALL keep err_cnt unaffected by mode, scrub_en and injection except through err.

Reset
REQ-027 SHALL, on an edge with rst_n=0, set c0=c1=c2=0 and err_cnt=0, overriding mode, scrub, injection and err_clr.
REQ-028 SHALL present q=0, err=0, copy_err=000 and err_cnt=0 from the first edge after reset until new stimulus arrives.
REQ-029 SHALL apply reset mid-operation, including with faults present, on the same edge with no residual state.

Verification (WIDTH=4, CNT_W=2 unless stated)
REQ-030 SHALL cover load: reset, then mode=01 din=A for 1 cycle, then hold -> q=A, err=0, copy_err=000, err_cnt=0.
REQ-031 SHALL cover a persistent single fault: from q=A, hold with inj_en=1 inj_copy=1 inj_bit=0 for 1 cycle, scrub_en=0 -> q=A, err=1, copy_err=010; err_cnt=1,2,3 after the next three edges, then stays 3 (saturation).
REQ-032 SHALL cover scrub and clear: from REQ-031, scrub_en=1 with err_clr=1 for 1 cycle -> err=0, copy_err=000, err_cnt=0, q=A.
REQ-033 SHALL cover shift and rotate: q=1010, mode=10 sin=1 -> q=0101; then mode=11 -> q=1010; then mode=11 -> q=0101.
REQ-034 SHALL cover injection during load and ignored injection: mode=01 din=F with inj_copy=2 inj_bit=3 -> q=F, copy_err=100; next cycle mode=01 din=F with inj_copy=3 -> copy_err=000, err=0.
REQ-035 SHALL cover reset mid-fault: fault present with err_cnt=2, rst_n=0 for 1 edge -> q=0, err=0, copy_err=000, err_cnt=0.

Source files
------------

// File: rtl/tmr_reg_bank.sv
// Triple-redundant shift/load register with bitwise majority vote, scrubbing,
// per-copy fault injection and a saturating disagreement counter.
module tmr_reg_bank #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    input  logic             scrub_en,
    input  logic             inj_en,
    input  logic [1:0]       inj_copy,
    input  logic [IW-1:0]    inj_bit,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic             err,
    output logic [2:0]       copy_err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_LOAD   = 2'b01,
        MODE_SHIFT  = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_t;

    logic [WIDTH-1:0] c     [3];
    logic [WIDTH-1:0] c_nxt [3];
    logic [WIDTH-1:0] n_word;
    logic [WIDTH-1:0] shl_word;
    logic [WIDTH-1:0] rol_word;
    logic [WIDTH-1:0] inj_mask;
    logic             keep_copies;

    always_comb begin
        q        = (c[0] & c[1]) | (c[0] & c[2]) | (c[1] & c[2]);
        err      = |((c[0] ^ c[1]) | (c[0] ^ c[2]));
        copy_err = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            copy_err[k] = |(c[k] ^ q);
        end
    end

    generate
        if (WIDTH == 1) begin : g_narrow
            assign shl_word = sin;
            assign rol_word = q;
        end else begin : g_wide
            assign shl_word = {q[WIDTH-2:0], sin};
            assign rol_word = {q[WIDTH-2:0], q[WIDTH-1]};
        end
    endgenerate

    always_comb begin
        n_word = q;
        case (mode_t'(mode))
            MODE_HOLD:   n_word = q;
            MODE_LOAD:   n_word = din;
            MODE_SHIFT:  n_word = shl_word;
            MODE_ROTATE: n_word = rol_word;
            default:     n_word = q;
        endcase
    end

    // An out-of-range inj_bit matches no mask position, so it injects nothing.
    always_comb begin
        inj_mask = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            inj_mask[b] = (32'(inj_bit) == b);
        end
    end

    // Plain hold keeps each copy as-is so faults persist until scrub or a write.
    assign keep_copies = (mode_t'(mode) == MODE_HOLD) && !scrub_en;

    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            c_nxt[k] = keep_copies ? c[k] : n_word;
            if (inj_en && (inj_copy == 2'(k))) begin
                c_nxt[k] = c_nxt[k] ^ inj_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 3; k++) begin
            if (!rst_n) begin
                c[k] <= '0;
            end else begin
                c[k] <= c_nxt[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tmr_reg_bank.sv
// Scoreboard bench for tmr_reg_bank (WIDTH=4, CNT_W=2): directed steps push
// hand-computed post-edge expectations, a monitor pops and compares them.
module tb_tmr_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [3:0] din;
    logic       sin;
    logic       scrub_en;
    logic       inj_en;
    logic [1:0] inj_copy;
    logic [1:0] inj_bit;
    logic       err_clr;
    logic [3:0] q;
    logic       err;
    logic [2:0] copy_err;
    logic [1:0] err_cnt;

    typedef struct packed {
        logic [3:0] q;
        logic       err;
        logic [2:0] copy_err;
        logic [1:0] cnt;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    total = 0;
    int    bad   = 0;

    tmr_reg_bank #(.WIDTH(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .din(din), .sin(sin),
        .scrub_en(scrub_en), .inj_en(inj_en), .inj_copy(inj_copy),
        .inj_bit(inj_bit), .err_clr(err_clr), .q(q), .err(err),
        .copy_err(copy_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input string nm, input logic r, input logic [1:0] md,
                        input logic [3:0] d, input logic s, input logic scr,
                        input logic ie, input logic [1:0] ic, input logic [1:0] ib,
                        input logic clr, input logic [3:0] eq, input logic ee,
                        input logic [2:0] ece, input logic [1:0] ecnt);
        exp_t e;
        @(negedge clk);
        rst_n = r; mode = md; din = d; sin = s; scrub_en = scr;
        inj_en = ie; inj_copy = ic; inj_bit = ib; err_clr = clr;
        e.q = eq; e.err = ee; e.copy_err = ece; e.cnt = ecnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                total++;
                if (q !== e.q) begin
                    bad++;
                    $display("FAIL %s q: got %h want %h", nm, q, e.q);
                end
                total++;
                if (err !== e.err) begin
                    bad++;
                    $display("FAIL %s err: got %b want %b", nm, err, e.err);
                end
                total++;
                if (copy_err !== e.copy_err) begin
                    bad++;
                    $display("FAIL %s copy_err: got %b want %b", nm, copy_err, e.copy_err);
                end
                total++;
                if (err_cnt !== e.cnt) begin
                    bad++;
                    $display("FAIL %s err_cnt: got %0d want %0d", nm, err_cnt, e.cnt);
                end
            end
        end
    end

    initial begin : stim
        int waited;
        //        name          rst md     din   sin scr ie ic     ib     clr  q     err cerr    cnt
        step("reset",        0, 2'b00, 4'h0, 0, 0, 0, 2'd3, 2'd0, 0, 4'h0, 0, 3'b000, 2'd0);
        step("post_reset",   1, 2'b00, 4'h0, 0, 0, 0, 2'd3, 2'd0, 0, 4'h0, 0, 3'b000, 2'd0);
        step("load_a",       1, 2'b01, 4'hA, 0, 0, 0, 2'd3, 2'd0, 0, 4'hA, 0, 3'b000, 2'd0);
        step("hold_a",       1, 2'b00, 4'h0, 0, 0, 0, 2'd3, 2'd0, 0, 4'hA, 0, 3'b000, 2'd0);
        step("inj_c1",       1, 2'b00, 4'h0, 0, 0, 1, 2'd1, 2'd0, 0, 4'hA, 1, 3'b010, 2'd0);
        step("persist_1",    1, 2'b00, 4'h0, 0, 0, 0, 2'd3, 2'd0, 0, 4'hA, 1, 3'b010, 2'd1);
        step("persist_2",    1, 2'b00, 4'h0, 0, 0, 0, 2'd3, 2'd0, 0, 4'hA, 1, 3'b010, 2'd2);
        step("persist_3",    1, 2'b00, 4'h0, 0, 0, 0, 2'd3, 2'd0, 0, 4'hA, 1, 3'b010, 2'd3);
        step("saturate",     1, 2'b00, 4'h0, 0, 0, 0, 2'd3, 2'd0, 0, 4'hA, 1, 3'b010, 2'd3);
        step("scrub_clr",    1, 2'b00, 4'h0, 0, 1, 0, 2'd3, 2'd0, 1, 4'hA, 0, 3'b000, 2'd0);
        step("hold_clean",   1, 2'b00, 4'h0, 0, 0, 0, 2'd3, 2'd0, 0, 4'hA, 0, 3'b000, 2'd0);
        step("shift_sin1",   1, 2'b10, 4'h0, 1, 0, 0, 2'd3, 2'd0, 0, 4'h5, 0, 3'b000, 2'd0);
        step("rotate_1",     1, 2'b11, 4'h0, 0, 0, 0, 2'd3, 2'd0, 0, 4'hA, 0, 3'b000, 2'd0);
        step("rotate_2",     1, 2'b11, 4'h0, 0, 0, 0, 2'd3, 2'd0, 0, 4'h5, 0, 3'b000, 2'd0);
        step("shift_sin0",   1, 2'b10, 4'h0, 0, 0, 0, 2'd3, 2'd0, 0, 4'hA, 0, 3'b000, 2'd0);
        step("load_inj_c2",  1, 2'b01, 4'hF, 0, 0, 1, 2'd2, 2'd3, 0, 4'hF, 1, 3'b100, 2'd0);
        step("load_no_tgt",  1, 2'b01, 4'hF, 0, 0, 1, 2'd3, 2'd0, 0, 4'hF, 0, 3'b000, 2'd1);
        step("clr_only",     1, 2'b00, 4'h0, 0, 0, 0, 2'd3, 2'd0, 1, 4'hF, 0, 3'b000, 2'd0);
        step("inj_c0",       1, 2'b00, 4'h0, 0, 0, 1, 2'd0, 2'd1, 0, 4'hF, 1, 3'b001, 2'd0);
        step("fault_cnt1",   1, 2'b00, 4'h0, 0, 0, 0, 2'd3, 2'd0, 0, 4'hF, 1, 3'b001, 2'd1);
        step("fault_cnt2",   1, 2'b00, 4'h0, 0, 0, 0, 2'd3, 2'd0, 0, 4'hF, 1, 3'b001, 2'd2);
        step("reset_mid",    0, 2'b01, 4'hF, 1, 1, 1, 2'd1, 2'd2, 0, 4'h0, 0, 3'b000, 2'd0);
        step("after_reset",  1, 2'b00, 4'h0, 0, 0, 0, 2'd3, 2'd0, 0, 4'h0, 0, 3'b000, 2'd0);
        step("dbl_a_c0",     1, 2'b00, 4'h0, 0, 0, 1, 2'd0, 2'd0, 0, 4'h0, 1, 3'b001, 2'd0);
        step("dbl_b_c1",     1, 2'b00, 4'h0, 0, 0, 1, 2'd1, 2'd0, 0, 4'h1, 1, 3'b100, 2'd1);
        step("load_fix",     1, 2'b01, 4'h3, 0, 0, 0, 2'd3, 2'd0, 0, 4'h3, 0, 3'b000, 2'd2);
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
